fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one in-flight synchronous ROM read feeding a DEPTH-entry FIFO.
// Define FETCH_QUEUE_PERF_EN to add the saturating starvation counter on stall_cnt.
module fetch_queue #(
  parameter int PC_W     = 16,
  parameter int INST_W   = 26,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [PC_W-1:0]          rom_addr,
  input  logic [INST_W-1:0]        rom_data,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic [INST_W-1:0]        inst_out,
  output logic [PC_W-1:0]          pc_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;

  logic [CW:0] occ;
  logic        issue;
  logic        push;
  logic        pop;

  assign count     = rst ? '0 : count_q;
  assign valid_out = (count != '0);
  assign inst_out  = mem_q[head_q].inst;
  assign pc_out    = mem_q[head_q].pc;

  // During a stall the outstanding address is replayed so rom_data
  // still matches req_pc when fetching resumes.
  assign rom_addr = rst ? RST_PC :
                    en  ? fetch_pc_q : req_pc_q;

  assign occ   = {1'b0, count_q} + {{CW{1'b0}}, req_valid_q};
  assign issue = en && !redirect && (occ < DEPTH_V);
  assign push  = en && !redirect && req_valid_q;
  assign pop   = en && valid_out && ready_in;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (en && redirect) begin
      fetch_pc_d  = redirect_pc;
      req_valid_d = 1'b0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
    end else if (en) begin
      req_valid_d = issue;
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
      end
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RST_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[tail_q] <= '{pc: req_pc_q, inst: rom_data};
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (en && !valid_out && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = rst ? '0 : stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-level model.
// Honours FETCH_QUEUE_PERF_EN for the expected stall_cnt.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] rom_addr;
  logic [25:0] rom_data = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [25:0] inst_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [2:0]  count;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  fetch_queue dut (
    .clk(clk), .rst(rst), .en(en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_out(inst_out), .pc_out(pc_out),
    .valid_out(valid_out), .ready_in(ready_in),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] rom_fn(input logic [15:0] a);
    return {~a[9:0], a};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Reference: a queue of fetched PCs, the next fetch PC and one in-flight slot.
  logic [15:0] mq [$];
  logic [15:0] m_pc = '0;
  logic [15:0] m_req_pc = '0;
  bit          m_req = 1'b0;
  int          m_stall = 0;

  always @(posedge clk) begin
    int sz;
    if (rst) begin
      mq.delete();
      m_pc = '0;
      m_req = 1'b0;
      m_req_pc = '0;
      m_stall = 0;
    end else if (en) begin
      sz = mq.size();
      if (sz == 0 && m_stall < 65535) m_stall++;
      if (sz != 0 && ready_in) void'(mq.pop_front());
      if (redirect) begin
        mq.delete();
        m_req = 1'b0;
        m_pc = redirect_pc;
      end else begin
        if (m_req) mq.push_back(m_req_pc);
        if (sz + int'(m_req) < 4) begin
          m_req = 1'b1;
          m_req_pc = m_pc;
          m_pc = m_pc + 16'd4;
        end else begin
          m_req = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; redirect = 1'b0; ready_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst = 1'b1; en = 1'b1; redirect = 1'b0; ready_in = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || rom_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_pre: count=%0d rom_addr=%h want 0/0000", count, rom_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 3'd0 || valid_out !== 1'b0 || rom_addr !== 16'h0 || stall_cnt !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold: count=%0d valid=%b rom_addr=%h stall=%0d want 0/0/0000/0",
                 count, valid_out, rom_addr, stall_cnt);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_c0: valid=%b want 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_c1: valid=%b want 0", valid_out);
    end
    tick();
    checks++;
    if (stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL perf_first: stall_cnt=%0d want %0d", stall_cnt, PERF ? 2 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      e = 16'(4 * k);
      checks++;
      if (valid_out !== 1'b1 || pc_out !== e || inst_out !== rom_fn(e) || count !== 3'd1) begin
        errors++;
        $display("FAIL reset_seq%0d: valid=%b pc=%h inst=%h count=%0d want 1/%h/%h/1",
                 k, valid_out, pc_out, inst_out, count, e, rom_fn(e));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (count > 3'd4) begin
        errors++;
        $display("FAIL bp_overflow: count=%0d want <=4", count);
      end
      tick();
    end
    #1;
    checks++;
    if (count !== 3'd4 || rom_addr !== 16'h0010 || pc_out !== 16'h0) begin
      errors++;
      $display("FAIL bp_full: count=%0d rom_addr=%h pc=%h want 4/0010/0000",
               count, rom_addr, pc_out);
    end
    ready_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = 16'(4 * k);
      #1;
      checks++;
      if (valid_out !== 1'b1 || pc_out !== e || inst_out !== rom_fn(e)) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%b pc=%h inst=%h want 1/%h/%h",
                 k, valid_out, pc_out, inst_out, e, rom_fn(e));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    #1;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL redir_pre: count=%0d want 3", count);
    end
    redirect = 1'b1; redirect_pc = 16'h0040; ready_in = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: count=%0d valid=%b want 0/0", count, valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL redir_r2: valid=%b want 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 16'h0040 || inst_out !== rom_fn(16'h0040)) begin
      errors++;
      $display("FAIL redir_target: valid=%b pc=%h want 1/0040", valid_out, pc_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 16'h0044) begin
      errors++;
      $display("FAIL redir_next: valid=%b pc=%h want 1/0044", valid_out, pc_out);
    end
  endtask

  task automatic test_stall();
    logic [15:0] e;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pc_out !== 16'h8 || count !== 3'd1 || valid_out !== 1'b1 ||
          rom_addr !== 16'hC || stall_cnt !== (PERF ? 16'd2 : 16'd0)) begin
        errors++;
        $display("FAIL stall_frozen%0d: pc=%h count=%0d valid=%b rom_addr=%h stall=%0d want 0008/1/1/000c/%0d",
                 i, pc_out, count, valid_out, rom_addr, stall_cnt, PERF ? 2 : 0);
      end
      tick();
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 16'(8 + 4 * k);
      #1;
      checks++;
      if (valid_out !== 1'b1 || pc_out !== e || inst_out !== rom_fn(e)) begin
        errors++;
        $display("FAIL stall_resume%0d: valid=%b pc=%h inst=%h want 1/%h/%h",
                 k, valid_out, pc_out, inst_out, e, rom_fn(e));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    redirect = 1'b1; redirect_pc = 16'hFFF8;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      e = 16'hFFF8 + 16'(4 * k);
      #1;
      checks++;
      if (valid_out !== 1'b1 || pc_out !== e || inst_out !== rom_fn(e)) begin
        errors++;
        $display("FAIL wrap%0d: valid=%b pc=%h want 1/%h", k, valid_out, pc_out, e);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] e_addr;
    logic [15:0] e_stall;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst         = ($urandom_range(0, 63) == 0);
      en          = ($urandom_range(0, 99) < 85);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC;
      ready_in    = ($urandom_range(0, 99) < 60);
      #1;
      e_addr  = rst ? 16'h0 : (en ? m_pc : m_req_pc);
      e_stall = (PERF && !rst) ? 16'(m_stall) : 16'h0;
      checks++;
      if (rom_addr !== e_addr || stall_cnt !== e_stall) begin
        errors++;
        $display("FAIL rnd_addr c%0d: rom_addr=%h stall=%0d want %h/%0d",
                 c, rom_addr, stall_cnt, e_addr, e_stall);
      end
      if (rst) begin
        checks++;
        if (count !== 3'd0 || valid_out !== 1'b0) begin
          errors++;
          $display("FAIL rnd_rst c%0d: count=%0d valid=%b want 0/0", c, count, valid_out);
        end
      end else begin
        checks++;
        if (count !== 3'(mq.size()) || valid_out !== (mq.size() != 0)) begin
          errors++;
          $display("FAIL rnd_count c%0d: count=%0d valid=%b want %0d/%b",
                   c, count, valid_out, mq.size(), mq.size() != 0);
        end else if (mq.size() != 0) begin
          checks++;
          if (pc_out !== mq[0] || inst_out !== rom_fn(mq[0])) begin
            errors++;
            $display("FAIL rnd_head c%0d: pc=%h inst=%h want %h/%h",
                     c, pc_out, inst_out, mq[0], rom_fn(mq[0]));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_stall();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
